// File: rtl/ex_stage_pkg.sv
// Shared ALU op/sel codes, divider state encoding and helpers for the execute stage.
package ex_stage_pkg;

  localparam int unsigned AluOpW   = 8;
  localparam int unsigned AluSelW  = 3;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned RegAddrW = 5;

  localparam logic            RstEnable = 1'b0;
  localparam logic [31:0]     ZeroWord  = 32'h0;

  localparam logic [AluOpW-1:0] OpNop   = 8'h00;
  localparam logic [AluOpW-1:0] OpAnd   = 8'h24;
  localparam logic [AluOpW-1:0] OpOr    = 8'h25;
  localparam logic [AluOpW-1:0] OpXor   = 8'h26;
  localparam logic [AluOpW-1:0] OpNor   = 8'h27;
  localparam logic [AluOpW-1:0] OpLui   = 8'h5c;
  localparam logic [AluOpW-1:0] OpSll   = 8'h7c;
  localparam logic [AluOpW-1:0] OpSrl   = 8'h02;
  localparam logic [AluOpW-1:0] OpSra   = 8'h03;
  localparam logic [AluOpW-1:0] OpSlt   = 8'h2a;
  localparam logic [AluOpW-1:0] OpSltu  = 8'h2b;
  localparam logic [AluOpW-1:0] OpAdd   = 8'h20;
  localparam logic [AluOpW-1:0] OpAddu  = 8'h21;
  localparam logic [AluOpW-1:0] OpSub   = 8'h22;
  localparam logic [AluOpW-1:0] OpSubu  = 8'h23;
  localparam logic [AluOpW-1:0] OpMfhi  = 8'h10;
  localparam logic [AluOpW-1:0] OpMthi  = 8'h11;
  localparam logic [AluOpW-1:0] OpMflo  = 8'h12;
  localparam logic [AluOpW-1:0] OpMtlo  = 8'h13;
  localparam logic [AluOpW-1:0] OpMult  = 8'h18;
  localparam logic [AluOpW-1:0] OpMultu = 8'h19;
  localparam logic [AluOpW-1:0] OpDiv   = 8'h1a;
  localparam logic [AluOpW-1:0] OpDivu  = 8'h1b;
  localparam logic [AluOpW-1:0] OpMul   = 8'ha9;
  localparam logic [AluOpW-1:0] OpJal   = 8'h50;

  localparam logic [AluSelW-1:0] SelNop   = 3'd0;
  localparam logic [AluSelW-1:0] SelLogic = 3'd1;
  localparam logic [AluSelW-1:0] SelShift = 3'd2;
  localparam logic [AluSelW-1:0] SelMove  = 3'd3;
  localparam logic [AluSelW-1:0] SelArith = 3'd4;
  localparam logic [AluSelW-1:0] SelMul   = 3'd5;
  localparam logic [AluSelW-1:0] SelJump  = 3'd6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Magnitude of a word; only treated as two's complement when is_signed is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// 32-cycle restoring radix-2 divider with sign fix-up; result is {remainder, quotient}.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  input  logic        hold,
  output logic [63:0] result,
  output logic        ready
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;

  logic [32:0] upper;
  logic [31:0] trial;
  logic        fits;
  logic [31:0] quot, rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;

    // Partial remainder after the left shift, 33 bits so the top bit is never lost.
    upper = acc_q[63:31];
    fits  = upper >= {1'b0, divisor_q};
    trial = upper[31:0] - divisor_q;

    unique case (state_q)
      DivFree: begin
        if (start && !flush) begin
          state_d    = (op2 == ZeroWord) ? DivByZero : DivOn;
          acc_d      = {32'h0, abs32(op1, signed_div)};
          divisor_d  = abs32(op2, signed_div);
          neg_quot_d = signed_div & (op1[31] ^ op2[31]);
          neg_rem_d  = signed_div & op1[31];
          cnt_d      = '0;
        end
      end
      DivOn: begin
        if (flush) begin
          state_d = DivFree;
        end else begin
          acc_d = fits ? {trial, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DivEnd;
        end
      end
      DivByZero: begin
        acc_d   = '0;
        state_d = flush ? DivFree : DivEnd;
      end
      DivEnd: begin
        if (flush || !hold) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      acc_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    quot   = neg_quot_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem    = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    result = {rem, quot};
    ready  = (state_q == DivEnd);
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU/multiplier plus the stalling iterative divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [AluOpW-1:0]   alu_op,
  input  logic [AluSelW-1:0]  alu_sel,
  input  logic [RegDataW-1:0] reg_data_1,
  input  logic [RegDataW-1:0] reg_data_2,
  input  logic [RegAddrW-1:0] reg_write_addr_i,
  input  logic                reg_write_en_i,
  input  logic [RegDataW-1:0] link_addr,
  input  logic                is_in_delayslot,
  input  logic [RegDataW-1:0] hi_i,
  input  logic [RegDataW-1:0] lo_i,
  input  logic                ex_hold,
  input  logic                flush,
  output logic [RegDataW-1:0] reg_write_data,
  output logic [RegAddrW-1:0] reg_write_addr_o,
  output logic                reg_write_en_o,
  output logic                hilo_write_en,
  output logic [RegDataW-1:0] hi_o,
  output logic [RegDataW-1:0] lo_o,
  output logic                is_in_delayslot_o,
  output logic                stall_req
);

  logic        is_div, signed_div, div_ready;
  logic [63:0] div_result;

  assign is_div     = (alu_op == OpDiv) || (alu_op == OpDivu);
  assign signed_div = (alu_op == OpDiv);

  ex_div u_ex_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .signed_div (signed_div),
    .op1        (reg_data_1),
    .op2        (reg_data_2),
    .flush      (flush),
    .hold       (ex_hold),
    .result     (div_result),
    .ready      (div_ready)
  );

  logic [4:0]  shamt;
  logic [31:0] sum, diff, logic_res, shift_res, arith_res, move_res, mul_a, mul_b;
  logic [63:0] mul_mag, mul_res;
  logic        mul_signed, mul_neg, ovf;

  always_comb begin
    shamt = reg_data_1[4:0];
    sum   = reg_data_1 + reg_data_2;
    diff  = reg_data_1 - reg_data_2;

    case (alu_op)
      OpAnd:   logic_res = reg_data_1 & reg_data_2;
      OpOr:    logic_res = reg_data_1 | reg_data_2;
      OpXor:   logic_res = reg_data_1 ^ reg_data_2;
      OpNor:   logic_res = ~(reg_data_1 | reg_data_2);
      OpLui:   logic_res = {reg_data_2[15:0], 16'h0};
      default: logic_res = ZeroWord;
    endcase

    case (alu_op)
      OpSll:   shift_res = reg_data_2 << shamt;
      OpSrl:   shift_res = reg_data_2 >> shamt;
      OpSra:   shift_res = $signed(reg_data_2) >>> shamt;
      default: shift_res = ZeroWord;
    endcase

    case (alu_op)
      OpAdd, OpAddu: arith_res = sum;
      OpSub, OpSubu: arith_res = diff;
      OpSlt:         arith_res = {31'h0, $signed(reg_data_1) < $signed(reg_data_2)};
      OpSltu:        arith_res = {31'h0, reg_data_1 < reg_data_2};
      default:       arith_res = ZeroWord;
    endcase

    case (alu_op)
      OpMfhi:  move_res = hi_i;
      OpMflo:  move_res = lo_i;
      default: move_res = ZeroWord;
    endcase

    // Overflow when like-signed inputs (ADD) or unlike-signed inputs (SUB) flip the sign.
    ovf = ((alu_op == OpAdd) && (reg_data_1[31] == reg_data_2[31]) &&
           (sum[31] != reg_data_1[31])) ||
          ((alu_op == OpSub) && (reg_data_1[31] != reg_data_2[31]) &&
           (diff[31] != reg_data_1[31]));

    mul_signed = (alu_op == OpMult) || (alu_op == OpMul);
    mul_a      = abs32(reg_data_1, mul_signed);
    mul_b      = abs32(reg_data_2, mul_signed);
    mul_mag    = {32'h0, mul_a} * {32'h0, mul_b};
    mul_neg    = mul_signed & (reg_data_1[31] ^ reg_data_2[31]);
    mul_res    = mul_neg ? (~mul_mag + 64'd1) : mul_mag;
  end

  always_comb begin
    reg_write_data    = ZeroWord;
    reg_write_addr_o  = '0;
    reg_write_en_o    = 1'b0;
    hilo_write_en     = 1'b0;
    hi_o              = ZeroWord;
    lo_o              = ZeroWord;
    is_in_delayslot_o = 1'b0;
    stall_req         = 1'b0;

    if (rst != RstEnable) begin
      reg_write_addr_o  = reg_write_addr_i;
      reg_write_en_o    = reg_write_en_i & ~ovf;
      is_in_delayslot_o = is_in_delayslot;

      unique case (alu_sel)
        SelLogic: reg_write_data = logic_res;
        SelShift: reg_write_data = shift_res;
        SelArith: reg_write_data = arith_res;
        SelMove:  reg_write_data = move_res;
        SelMul:   reg_write_data = mul_res[31:0];
        SelJump:  reg_write_data = link_addr;
        default:  reg_write_data = ZeroWord;
      endcase

      case (alu_op)
        OpMthi: begin
          hilo_write_en = 1'b1;
          hi_o          = reg_data_1;
          lo_o          = lo_i;
        end
        OpMtlo: begin
          hilo_write_en = 1'b1;
          hi_o          = hi_i;
          lo_o          = reg_data_1;
        end
        OpMult, OpMultu: begin
          hilo_write_en = 1'b1;
          hi_o          = mul_res[63:32];
          lo_o          = mul_res[31:0];
        end
        OpDiv, OpDivu: begin
          // A flushed divide neither stalls nor commits.
          stall_req = ~div_ready & ~flush;
          if (div_ready && !flush) begin
            hilo_write_en = 1'b1;
            hi_o          = div_result[63:32];
            lo_o          = div_result[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alu_op_v;
  logic [2:0]  alu_sel_v;
  logic [31:0] d1, d2, link_v, hi_v, lo_v;
  logic [4:0]  waddr;
  logic        we_i, ds_i, hold_v, flush_v;

  logic [31:0] reg_write_data, hi_o, lo_o;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_en_o, hilo_write_en, is_in_delayslot_o, stall_req;

  typedef struct packed {
    logic [31:0] rwd;
    logic [4:0]  rwa;
    logic        rwe;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ds;
    logic        stall;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  logic [7:0] op_list [23] = '{OpAnd, OpOr, OpXor, OpNor, OpLui, OpSll, OpSrl, OpSra, OpAdd,
                               OpAddu, OpSub, OpSubu, OpSlt, OpSltu, OpMfhi, OpMflo, OpMthi,
                               OpMtlo, OpMult, OpMultu, OpMul, OpJal, OpNop};

  always #5 clk = ~clk;

  ex_stage dut (
    .clk               (clk),
    .rst               (rst),
    .alu_op            (alu_op_v),
    .alu_sel           (alu_sel_v),
    .reg_data_1        (d1),
    .reg_data_2        (d2),
    .reg_write_addr_i  (waddr),
    .reg_write_en_i    (we_i),
    .link_addr         (link_v),
    .is_in_delayslot   (ds_i),
    .hi_i              (hi_v),
    .lo_i              (lo_v),
    .ex_hold           (hold_v),
    .flush             (flush_v),
    .reg_write_data    (reg_write_data),
    .reg_write_addr_o  (reg_write_addr_o),
    .reg_write_en_o    (reg_write_en_o),
    .hilo_write_en     (hilo_write_en),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .stall_req         (stall_req)
  );

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {reg_write_data, reg_write_addr_o, reg_write_en_o, hilo_write_en, hi_o, lo_o,
           is_in_delayslot_o, stall_req};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got rwd=%h rwa=%0d rwe=%b hwe=%b hi=%h lo=%h ds=%b stall=%b | want rwd=%h rwa=%0d rwe=%b hwe=%b hi=%h lo=%h ds=%b stall=%b",
                 nm, a.rwd, a.rwa, a.rwe, a.hwe, a.hi, a.lo, a.ds, a.stall,
                 e.rwd, e.rwa, e.rwe, e.hwe, e.hi, e.lo, e.ds, e.stall);
      end
    end
  end

  task automatic check_now(input exp_t e, input string nm);
    exp_t a;
    a = {reg_write_data, reg_write_addr_o, reg_write_en_o, hilo_write_en, hi_o, lo_o,
         is_in_delayslot_o, stall_req};
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s (immediate): got hwe=%b hi=%h lo=%h stall=%b | want hwe=%b hi=%h lo=%h stall=%b",
               nm, a.hwe, a.hi, a.lo, a.stall, e.hwe, e.hi, e.lo, e.stall);
    end
  endtask

  task automatic step(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      OpAnd, OpOr, OpXor, OpNor, OpLui:                  return SelLogic;
      OpSll, OpSrl, OpSra:                               return SelShift;
      OpAdd, OpAddu, OpSub, OpSubu, OpSlt, OpSltu:       return SelArith;
      OpMfhi, OpMflo:                                    return SelMove;
      OpMul:                                             return SelMul;
      OpJal:                                             return SelJump;
      default:                                           return SelNop;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h7fffffff;
      1:       return 32'h80000000;
      2:       return 32'hffffffff;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_side();
    waddr  = 5'($urandom_range(0, 31));
    we_i   = 1'($urandom_range(0, 1));
    ds_i   = 1'($urandom_range(0, 1));
    hi_v   = $urandom;
    lo_v   = $urandom;
    link_v = $urandom;
  endtask

  // Reference behaviour of one non-divide instruction from the current inputs.
  function automatic exp_t model_comb();
    exp_t        e;
    longint      s;
    logic [63:0] p;
    logic [4:0]  sh;
    e     = '0;
    e.rwa = waddr;
    e.rwe = we_i;
    e.ds  = ds_i;
    sh    = d1[4:0];
    case (alu_op_v)
      OpAnd:  e.rwd = d1 & d2;
      OpOr:   e.rwd = d1 | d2;
      OpXor:  e.rwd = d1 ^ d2;
      OpNor:  e.rwd = ~(d1 | d2);
      OpLui:  e.rwd = {d2[15:0], 16'h0};
      OpSll:  e.rwd = d2 << sh;
      OpSrl:  e.rwd = d2 >> sh;
      OpSra:  e.rwd = (d2 >> sh) | (d2[31] ? ~(32'hffffffff >> sh) : 32'h0);
      OpAdd, OpSub: begin
        if (alu_op_v == OpAdd) s = longint'($signed(d1)) + longint'($signed(d2));
        else                   s = longint'($signed(d1)) - longint'($signed(d2));
        e.rwd = s[31:0];
        if (s > 64'sd2147483647 || s < -64'sd2147483648) e.rwe = 1'b0;
      end
      OpAddu: e.rwd = d1 + d2;
      OpSubu: e.rwd = d1 - d2;
      OpSlt:  e.rwd = ($signed(d1) < $signed(d2)) ? 32'd1 : 32'd0;
      OpSltu: e.rwd = (d1 < d2) ? 32'd1 : 32'd0;
      OpMfhi: e.rwd = hi_v;
      OpMflo: e.rwd = lo_v;
      OpMthi: begin e.hwe = 1'b1; e.hi = d1; e.lo = lo_v; end
      OpMtlo: begin e.hwe = 1'b1; e.hi = hi_v; e.lo = d1; end
      OpMult: begin
        p = longint'($signed(d1)) * longint'($signed(d2));
        e.hwe = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
      end
      OpMultu: begin
        p = {32'h0, d1} * {32'h0, d2};
        e.hwe = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
      end
      OpMul: begin
        p = longint'($signed(d1)) * longint'($signed(d2));
        e.rwd = p[31:0];
      end
      OpJal:  e.rwd = link_v;
      default: ;
    endcase
    return e;
  endfunction

  task automatic div_model(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] q, output logic [31:0] r);
    longint lq, lr;
    if (y == 32'h0) begin
      q = '0; r = '0;
    end else if (sgn) begin
      lq = longint'($signed(x)) / longint'($signed(y));
      lr = longint'($signed(x)) % longint'($signed(y));
      q = lq[31:0]; r = lr[31:0];
    end else begin
      q = x / y; r = x % y;
    end
  endtask

  task automatic div_issue(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    rand_side();
    alu_op_v  = sgn ? OpDiv : OpDivu;
    alu_sel_v = SelNop;
    d1 = x; d2 = y;
    hold_v = 1'b0; flush_v = 1'b0;
  endtask

  task automatic div_stall_cycles(input int n, input string nm);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = model_comb();
      e.stall = 1'b1;
      step(e, $sformatf("%s_stall%0d", nm, i));
    end
  endtask

  // Full divide: stalls until the result cycle, which is then held for hold_n extra cycles.
  task automatic do_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input int hold_n, input string nm);
    logic [31:0] q, r;
    exp_t        e;
    div_issue(sgn, x, y);
    div_model(sgn, x, y, q, r);
    div_stall_cycles((y == 32'h0) ? 2 : 33, nm);
    for (int i = 0; i <= hold_n; i++) begin
      hold_v = (i < hold_n);
      e = model_comb();
      e.hwe = 1'b1; e.hi = r; e.lo = q;
      if (i == 0) check_now(e, $sformatf("%s_wait_expired", nm));
      step(e, $sformatf("%s_result%0d", nm, i));
    end
    hold_v = 1'b0;
  endtask

  task automatic directed(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] rwd, input logic rwe, input logic hwe,
                          input logic [31:0] hi, input logic [31:0] lo, input string nm);
    exp_t e;
    alu_op_v = op; alu_sel_v = sel_of(op); d1 = x; d2 = y;
    waddr = 5'd9; we_i = 1'b1; ds_i = 1'b0;
    hi_v = 32'haaaa0000; lo_v = 32'h55550000; link_v = 32'h00400010;
    e = '0;
    e.rwd = rwd; e.rwa = 5'd9; e.rwe = rwe; e.hwe = hwe; e.hi = hi; e.lo = lo;
    step(e, nm);
  endtask

  task automatic set_nop();
    rand_side();
    alu_op_v = OpNop; alu_sel_v = SelNop;
    d1 = $urandom; d2 = $urandom;
  endtask

  task automatic rand_comb(input int n);
    for (int i = 0; i < n; i++) begin
      rand_side();
      alu_op_v  = op_list[$urandom_range(0, 22)];
      alu_sel_v = sel_of(alu_op_v);
      d1 = rand_word();
      d2 = rand_word();
      step(model_comb(), $sformatf("rand_op%h", alu_op_v));
    end
  endtask

  initial begin
    rst = 1'b0; hold_v = 1'b0; flush_v = 1'b0;
    set_nop();
    @(posedge clk);
    #1;
    check_now('0, "reset_state");

    // Outputs must read zero under reset, even with a divide presented.
    for (int i = 0; i < 3; i++) begin
      div_issue(1'b1, $urandom, $urandom);
      step('0, $sformatf("reset%0d", i));
    end
    rst = 1'b1;

    directed(OpAdd,  32'h7fffffff, 32'h1, 32'h80000000, 1'b0, 1'b0, 0, 0, "add_ovf");
    directed(OpAddu, 32'h7fffffff, 32'h1, 32'h80000000, 1'b1, 1'b0, 0, 0, "addu_wrap");
    directed(OpSub,  32'h80000000, 32'h1, 32'h7fffffff, 1'b0, 1'b0, 0, 0, "sub_ovf");
    directed(OpSra,  32'd4, 32'hf0000000, 32'hff000000, 1'b1, 1'b0, 0, 0, "sra");
    directed(OpSlt,  32'hffffffff, 32'h1, 32'h1, 1'b1, 1'b0, 0, 0, "slt");
    directed(OpSltu, 32'hffffffff, 32'h1, 32'h0, 1'b1, 1'b0, 0, 0, "sltu");
    directed(OpMult, 32'hfffffffd, 32'd5, 32'h0, 1'b1, 1'b1, 32'hffffffff, 32'hfffffff1,
             "mult");
    directed(OpMthi, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1234, 32'h55550000, "mthi");
    directed(OpJal,  32'h0, 32'h0, 32'h00400010, 1'b1, 1'b0, 0, 0, "jal");

    do_div(1'b1, 32'hfffffff9, 32'd2, 0, "div_m7_2");
    do_div(1'b0, 32'd10, 32'd0, 0, "divu_by0");
    do_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    do_div(1'b1, 32'h80000000, 32'hffffffff, 3, "div_hold");

    // Flush mid-division, then confirm a fresh divide takes the full latency.
    div_issue(1'b1, 32'd1000, 32'd7);
    div_stall_cycles(10, "flush_pre");
    flush_v = 1'b1;
    step(model_comb(), "flush_cycle");
    flush_v = 1'b0;
    set_nop();
    step(model_comb(), "after_flush");
    do_div(1'b1, 32'd1000, 32'd7, 0, "div_after_flush");

    // Reset mid-division.
    div_issue(1'b0, 32'd12345, 32'd11);
    div_stall_cycles(5, "rst_pre");
    rst = 1'b0;
    step('0, "reset_mid");
    rst = 1'b1;
    set_nop();
    step(model_comb(), "after_reset");
    do_div(1'b0, 32'd12345, 32'd11, 0, "div_after_reset");

    rand_comb(120);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] y;
      y = ($urandom_range(0, 3) == 0) ? 32'h0 : rand_word();
      do_div(1'($urandom_range(0, 1)), rand_word(), y, $urandom_range(0, 2),
             $sformatf("rand_div%0d", i));
      rand_comb(5);
    end

    set_nop();
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
